// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - RV32I memory-stage load/store unit
// Issues dmem requests, aligns store lanes, extends load data and stalls the pipe while a load is in flight.
module mem_stage_lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_out_mem,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr_mem,
  input  logic        wb_en_mem,
  input  logic        flush_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        wb_en_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] wb_data_out,
  output logic        mem_exc,
  output logic [31:0] exc_addr
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] exc_addr_q, exc_addr_d;
  logic        flushed_q, flushed_d;

  logic        is_load, is_store, mem_op;
  logic        f3_legal, misaligned;
  logic [1:0]  size;
  logic [31:0] lane_word, load_data;
  logic [3:0]  strb;

  always_comb begin
    is_load    = mem_valid & mem_read;
    is_store   = mem_valid & mem_write & ~mem_read;
    mem_op     = is_load | is_store;
    size       = funct3[1:0];
    if (is_load) begin
      f3_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    end else begin
      f3_legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
    end
    misaligned = ((size == 2'b01) && alu_out_mem[0]) ||
                 ((size == 2'b10) && (alu_out_mem[1:0] != 2'b00));
  end

  // Shift the addressed byte/half down to bit 0 before extension.
  always_comb begin
    lane_word = dmem_rdata >> {alu_out_mem[1:0], 3'b000};
    case (funct3)
      3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b100:  load_data = {24'h0, lane_word[7:0]};
      3'b101:  load_data = {16'h0, lane_word[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    case (size)
      2'b00: begin
        strb       = 4'b0001 << alu_out_mem[1:0];
        dmem_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb       = 4'b0011 << {alu_out_mem[1], 1'b0};
        dmem_wdata = {2{store_data[15:0]}};
      end
      default: begin
        strb       = 4'hF;
        dmem_wdata = store_data;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    exc_addr_d  = exc_addr_q;
    flushed_d   = flushed_q;
    dmem_req    = 1'b0;
    stall_mem   = 1'b0;
    wb_en_out   = 1'b0;
    wb_data_out = alu_out_mem;
    mem_exc     = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          flushed_d = 1'b0;
          cnt_d     = 8'd0;
          if (flush_mem) begin
            wb_en_out = 1'b0;
          end else if (!mem_op) begin
            wb_en_out = mem_valid & wb_en_mem;
          end else if (!f3_legal || misaligned) begin
            mem_exc    = 1'b1;
            exc_addr_d = alu_out_mem;
          end else begin
            dmem_req  = 1'b1;
            stall_mem = ~(is_store & dmem_gnt);
            if (is_load && dmem_gnt) begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          stall_mem = 1'b1;
          if (flush_mem) begin
            flushed_d = 1'b1;
          end
          // A response arriving on the last allowed cycle beats the timeout.
          if (dmem_rvalid) begin
            stall_mem   = 1'b0;
            wb_en_out   = wb_en_mem & ~(flushed_q | flush_mem);
            wb_data_out = load_data;
            state_d     = IDLE;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            stall_mem  = 1'b0;
            mem_exc    = 1'b1;
            exc_addr_d = alu_out_mem;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      exc_addr_q <= 32'h0;
      flushed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exc_addr_q <= exc_addr_d;
      flushed_q  <= flushed_d;
    end
  end

  assign dmem_we     = dmem_req & is_store;
  assign dmem_wstrb  = dmem_we ? strb : 4'h0;
  assign dmem_addr   = {alu_out_mem[31:2], 2'b00};
  assign rd_addr_out = rd_addr_mem;
  assign exc_addr    = exc_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu
// Driver pushes expected retirements from a behavioural model; a negedge monitor pops and compares.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_out_mem, store_data;
  logic [4:0]  rd_addr_mem;
  logic        wb_en_mem, flush_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_mem, wb_en_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] wb_data_out;
  logic        mem_exc;
  logic [31:0] exc_addr;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .alu_out_mem(alu_out_mem), .store_data(store_data), .rd_addr_mem(rd_addr_mem),
    .wb_en_mem(wb_en_mem), .flush_mem(flush_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem), .wb_en_out(wb_en_out),
    .rd_addr_out(rd_addr_out), .wb_data_out(wb_data_out), .mem_exc(mem_exc), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [31:0] eaddr;
    int          stalls;
    int          g;
    logic        issues;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] daddr;
    logic        retire_req;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  int          stall_cnt = 0;
  bit          exc_pend = 1'b0;
  logic [31:0] exc_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_req(input exp_t e);
    chk("dmem_addr", dmem_addr, e.daddr);
    chk("dmem_we", dmem_we, e.we);
    chk("dmem_wstrb", dmem_wstrb, e.wstrb);
    if (e.we) chk("dmem_wdata", dmem_wdata, e.wdata);
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (exc_pend) begin
        chk("exc_addr", exc_addr, exc_exp);
        exc_pend = 1'b0;
      end
      if (!mem_valid) begin
        chk("idle_stall", stall_mem, 0);
        chk("idle_req", dmem_req, 0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_activity", 1, 0);
      end else if (stall_mem) begin
        chk("exc_in_stall", mem_exc, 0);
        if (exp_q[0].issues) begin
          chk("req_in_stall", dmem_req, (stall_cnt <= exp_q[0].g) ? 1 : 0);
          if (dmem_req) chk_req(exp_q[0]);
        end
        stall_cnt++;
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("stall_cycles", stall_cnt, e.stalls);
        chk("wb_en_out", wb_en_out, e.wb_en);
        if (e.wb_en) begin
          chk("wb_data_out", wb_data_out, e.data);
          chk("rd_addr_out", rd_addr_out, e.rd);
        end
        chk("mem_exc", mem_exc, e.exc);
        chk("retire_req", dmem_req, e.retire_req);
        if (dmem_req) chk_req(e);
        if (e.exc) begin
          exc_pend = 1'b1;
          exc_exp  = e.eaddr;
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic set_idle();
    mem_valid = 0; mem_read = 0; mem_write = 0; flush_mem = 0;
    dmem_gnt = 0; dmem_rvalid = 0;
    alu_out_mem = $urandom(); store_data = $urandom(); dmem_rdata = $urandom();
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    set_idle();
  endtask

  // f > 0 pulses flush_mem in that WAIT cycle of a load.
  task automatic run_txn(input logic rd_, input logic wr_, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic wben, input bit fstart,
                         input int g, input int l, input int f);
    exp_t e;
    int   off, v, sz;
    bit   legal, answered;
    off = int'(addr[1:0]);
    sz  = int'(f3[1:0]);
    e = '{wb_en:0, rd:rd, data:addr, exc:0, eaddr:addr, stalls:0, g:g, issues:0,
          we:0, wstrb:0, wdata:0, daddr:(addr / 4) * 4, retire_req:0};
    answered = (l <= TO);
    if (!rd_ && !wr_) begin
      e.wb_en = wben & !fstart;
    end else if (!fstart) begin
      if (rd_) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      else     legal = (f3 <= 2);
      if ((sz == 1 && off % 2 != 0) || (sz == 2 && off != 0)) legal = 0;
      if (!legal) begin
        e.exc = 1;
      end else if (wr_) begin
        e.issues = 1; e.we = 1; e.stalls = g; e.retire_req = 1;
        if (sz == 0) begin
          e.wstrb = 4'(1 << off);
          e.wdata = (sdata % 256) * 32'h01010101;
        end else if (sz == 1) begin
          e.wstrb = 4'(3 << (2 * (off / 2)));
          e.wdata = (sdata % 65536) * 32'h00010001;
        end else begin
          e.wstrb = 4'hF;
          e.wdata = sdata;
        end
      end else begin
        e.issues = 1;
        if (answered) begin
          e.stalls = g + l;
          e.wb_en  = wben & (f == 0);
          if (sz == 2) begin
            e.data = rdata;
          end else begin
            v = (sz == 0) ? int'((rdata >> (8 * off)) % 256) : int'((rdata >> (8 * off)) % 65536);
            if (!f3[2] && sz == 0 && v >= 128)   v -= 256;
            if (!f3[2] && sz == 1 && v >= 32768) v -= 65536;
            e.data = 32'(v);
          end
        end else begin
          e.stalls = g + TO;
          e.exc    = 1;
        end
      end
    end
    exp_q.push_back(e);
    for (int c = 0; c <= e.stalls; c++) begin
      @(posedge clk); #1;
      mem_valid = 1; mem_read = rd_; mem_write = wr_; funct3 = f3;
      alu_out_mem = addr; store_data = sdata; rd_addr_mem = rd; wb_en_mem = wben;
      dmem_rdata  = rdata;
      dmem_gnt    = e.issues && (c == g);
      dmem_rvalid = e.issues && rd_ && answered && (c == g + l);
      flush_mem   = fstart || (f > 0 && c == g + f);
    end
  endtask

  initial begin
    logic [31:0] a;
    int kind, g, l, f;
    logic [2:0] f3;
    bit fs;

    rst = 1;
    set_idle();
    funct3 = 3'b010; rd_addr_mem = 5'd1; wb_en_mem = 1;
    mem_valid = 1; mem_read = 1; alu_out_mem = 32'h40; dmem_gnt = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall_mem, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_exc", mem_exc, 0);
    chk("rst_wb_en", wb_en_out, 0);
    @(posedge clk); #1;
    rst = 0;
    set_idle();
    @(negedge clk);
    chk("rst_exc_addr", exc_addr, 0);
    mon_en = 1;

    run_txn(0, 0, 3'b000, 32'h1234, 0, 0, 5'd5, 1, 0, 0, 0, 0);
    run_txn(1, 0, 3'b000, 32'h103, 0, 32'h80AABBCC, 5'd7, 1, 0, 0, 3, 0);
    run_txn(1, 0, 3'b100, 32'h103, 0, 32'h80AABBCC, 5'd7, 1, 0, 0, 3, 0);
    run_txn(0, 1, 3'b001, 32'h202, 32'hDEADBEEF, 0, 5'd0, 0, 0, 2, 1, 0);
    run_txn(1, 0, 3'b010, 32'h005, 0, 0, 5'd3, 1, 0, 0, 1, 0);
    idle_cycle();
    run_txn(1, 0, 3'b010, 32'h300, 0, 32'h11223344, 5'd9, 1, 0, 0, 3, 1);
    run_txn(1, 0, 3'b010, 32'h400, 0, 0, 5'd9, 1, 0, 0, 99, 0);
    idle_cycle();
    run_txn(1, 0, 3'b101, 32'h402, 0, 32'hF00DCAFE, 5'd4, 1, 0, 1, TO, 0);
    run_txn(1, 0, 3'b001, 32'h402, 0, 32'hF00DCAFE, 5'd4, 1, 0, 0, 1, 0);

    // Reset while a load is outstanding, then a stray rvalid in IDLE.
    idle_cycle();
    @(negedge clk);
    mon_en = 0;
    @(posedge clk); #1;
    mem_valid = 1; mem_read = 1; funct3 = 3'b010; alu_out_mem = 32'h80; dmem_gnt = 1;
    @(posedge clk); #1;
    dmem_gnt = 0; rst = 1;
    @(negedge clk);
    chk("rst_wait_stall", stall_mem, 0);
    chk("rst_wait_req", dmem_req, 0);
    @(posedge clk); #1;
    rst = 0; mem_read = 0; wb_en_mem = 1; rd_addr_mem = 5'd2; alu_out_mem = 32'h55;
    dmem_rvalid = 1; dmem_rdata = 32'hAAAA5555;
    @(negedge clk);
    chk("post_rst_stall", stall_mem, 0);
    chk("post_rst_req", dmem_req, 0);
    chk("stray_rvalid_data", wb_data_out, 32'h55);
    @(posedge clk); #1;
    set_idle();
    stall_cnt = 0;
    mon_en = 1;

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      a  = $urandom();
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) != 0) begin
        if (kind < 6) f3 = (f3 % 2 == 0) ? 3'b010 : (f3 > 3 ? 3'b100 + 3'(f3 % 2) : 3'(f3 % 3));
        else          f3 = 3'(f3 % 3);
      end
      if ($urandom_range(0, 1) == 0) a = (f3[1:0] == 2'b10) ? (a / 4) * 4 : (a / 2) * 2;
      g  = $urandom_range(0, 3);
      l  = $urandom_range(1, 6);
      fs = ($urandom_range(0, 9) == 0);
      f  = 0;
      if (kind >= 2 && kind < 6 && !fs && $urandom_range(0, 3) == 0)
        f = $urandom_range(1, (l < TO) ? l : TO);
      if (kind < 2)      run_txn(0, 0, f3, a, $urandom(), $urandom(), 5'($urandom()), 1'($urandom()), fs, 0, 1, 0);
      else if (kind < 6) run_txn(1, 0, f3, a, $urandom(), $urandom(), 5'($urandom()), 1'($urandom()), fs, g, l, f);
      else if (kind < 9) run_txn(0, 1, f3, a, $urandom(), $urandom(), 5'($urandom()), 1'($urandom()), fs, g, l, 0);
      else               idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
